reg_hazard_scoreboard: RTL

- Consumer of the decode-stage register IDs. It takes the read-register-1, read-register-2 and write-register fields, which are 7-bit IDs.
- ID encoding: 0 = none/$zero, 1..31 = GPR, 33 = HI/LO.
- Tracks in-flight destination IDs through the EX/MEM/WB stages.
- Produces the decode stall, the operand forwarding selects and the multiply/divide busy interlock.
- Sits between decode and the pipeline control of the 5-stage MIPS core.

---
 rtl/reg_hazard_scoreboard_pkg.sv | 36 +++
 rtl/reg_hazard_scoreboard_if.sv | 45 ++++
 rtl/reg_hazard_scoreboard_fwd_match.sv | 47 ++++
 rtl/reg_hazard_scoreboard.sv | 121 ++++++++++++
 4 files changed

// File: rtl/reg_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_hazard_scoreboard_pkg
// Description : Shared types and constants for the register hazard scoreboard.
//               Holds the register-ID width, the special IDs, the forward
//               select encoding and the pipe-entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_hazard_scoreboard_pkg;

    localparam int REG_ID_W = 7;

    localparam logic [REG_ID_W-1:0] HILO_ID  = REG_ID_W'(33);
    localparam logic [REG_ID_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // One in-flight instruction: valid, destination ID, produced by a load.
    typedef struct packed {
        logic                v;
        logic [REG_ID_W-1:0] wr;
        logic                ld;
    } pipe_entry_t;

    // An entry supplies a source only when it is live, writes a real register
    // and the source itself names a real register.
    function automatic logic entry_match(input pipe_entry_t e,
                                         input logic [REG_ID_W-1:0] s);
        return e.v && (e.wr != REG_ZERO) && (e.wr == s) && (s != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_hazard_scoreboard_if
// Description : Decode-to-scoreboard interface. The master side is decode /
//               pipeline control, the slave side is the scoreboard.
//               Optional macro HAZARD_STATS_EN adds the stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_hazard_scoreboard_if;
    import reg_hazard_scoreboard_pkg::*;

    logic                id_valid;
    logic [REG_ID_W-1:0] id_rr1;
    logic [REG_ID_W-1:0] id_rr2;
    logic [REG_ID_W-1:0] id_wr;
    logic                id_is_load;
    logic                id_is_md;
    logic                flush;
    logic                stall;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]         stall_cnt;
    logic [31:0]         md_stall_cnt;
`endif

    modport master (
        output id_valid, id_rr1, id_rr2, id_wr, id_is_load, id_is_md, flush,
        input  stall, fwd_a, fwd_b, md_busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt, md_stall_cnt
`endif
    );

    modport slave (
        input  id_valid, id_rr1, id_rr2, id_wr, id_is_load, id_is_md, flush,
        output stall, fwd_a, fwd_b, md_busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt, md_stall_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/reg_hazard_scoreboard_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : reg_hazard_scoreboard_fwd_match
// Description : Matches one source register ID against the EX/MEM/WB entries
//               and priority-encodes the forward select (youngest wins).
//               Also flags a hit on a load still sitting in EX.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_hazard_scoreboard_fwd_match
    import reg_hazard_scoreboard_pkg::*;
(
    input  wire logic [REG_ID_W-1:0] i_src,
    input  wire pipe_entry_t         i_ex,
    input  wire pipe_entry_t         i_mem,
    input  wire pipe_entry_t         i_wb,
    output logic [1:0]               o_sel,
    output logic                     o_ld_hit
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused_ld;

    assign w_ex_hit  = entry_match(i_ex,  i_src);
    assign w_mem_hit = entry_match(i_mem, i_src);
    assign w_wb_hit  = entry_match(i_wb,  i_src);

    // Only the EX entry can cause a load-use stall; older loads have data.
    assign w_unused_ld = i_mem.ld | i_wb.ld;

    // Youngest producer wins: EX over MEM over WB, otherwise the regfile.
    always_comb begin
        o_sel    = FWD_RF;
        o_ld_hit = 1'b0;
        if (w_ex_hit) begin
            o_sel    = FWD_EX;
            o_ld_hit = i_ex.ld;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_hazard_scoreboard
// Description : Decode-stage hazard unit for the 5-stage MIPS core. Tracks
//               in-flight destinations through EX/MEM/WB, produces operand
//               forward selects, the load-use / HI-LO stall and md_busy.
//               Optional macro HAZARD_STATS_EN adds stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int MD_LATENCY = 4
)
(
    input  wire logic               clk,
    input  wire logic               rst,
    reg_hazard_scoreboard_if.slave  sb
);

    localparam logic [3:0] c_md_load = 4'(MD_LATENCY);

    pipe_entry_t r_ex;
    pipe_entry_t r_mem;
    pipe_entry_t r_wb;
    logic [3:0]  r_md_cnt;

    logic w_ld_hit_a;
    logic w_ld_hit_b;
    logic w_md_busy;
    logic w_hilo_src;
    logic w_md_stall;
    logic w_lu_stall;
    logic w_stall;
    logic w_md_issue;

    reg_hazard_scoreboard_fwd_match u_match_a (
        .i_src    (sb.id_rr1),
        .i_ex     (r_ex),
        .i_mem    (r_mem),
        .i_wb     (r_wb),
        .o_sel    (sb.fwd_a),
        .o_ld_hit (w_ld_hit_a)
    );

    reg_hazard_scoreboard_fwd_match u_match_b (
        .i_src    (sb.id_rr2),
        .i_ex     (r_ex),
        .i_mem    (r_mem),
        .i_wb     (r_wb),
        .o_sel    (sb.fwd_b),
        .o_ld_hit (w_ld_hit_b)
    );

    assign w_md_busy  = (r_md_cnt != 4'd0);
    assign w_hilo_src = (sb.id_rr1 == HILO_ID) || (sb.id_rr2 == HILO_ID);

    // HI/LO not ready: block readers of HI/LO and any second MULTU/DIVU.
    assign w_md_stall = w_md_busy && sb.id_valid && (w_hilo_src || sb.id_is_md);
    assign w_lu_stall = sb.id_valid && (w_ld_hit_a || w_ld_hit_b);

    // A redirect discards the decode slot, so nothing there can stall.
    assign w_stall    = !sb.flush && (w_lu_stall || w_md_stall);
    assign w_md_issue = sb.id_valid && sb.id_is_md && !w_stall && !sb.flush;

    assign sb.stall   = w_stall;
    assign sb.md_busy = w_md_busy;

    // Shift the destination tracker; stalled or flushed decode enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_stall || sb.flush || !sb.id_valid) begin
                r_ex <= '0;
            end else begin
                r_ex <= '{v: 1'b1, wr: sb.id_wr, ld: sb.id_is_load};
            end
        end
    end

    // Multiply/divide busy countdown, reloaded on each accepted MULTU/DIVU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= 4'd0;
        end else if (w_md_issue) begin
            r_md_cnt <= c_md_load;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_md_stall_cnt;

    // Free-running stall statistics; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt    <= 32'd0;
            r_md_stall_cnt <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_stall && w_md_stall) begin
                r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
            end
        end
    end

    assign sb.stall_cnt    = r_stall_cnt;
    assign sb.md_stall_cnt = r_md_stall_cnt;
`endif

endmodule
`default_nettype wire
